fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decoder.
- Owns the PC and issues word-aligned requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small FIFO and presents ir/pc to decode with a valid/ready handshake.
- Handles redirects from execute (branch/JAL/JALR): flushes the buffer and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 194 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word-aligned imem requests, buffers responses for decode. Optional same-cycle bypass: FETCH_BYPASS_EN.
// Latency: request accepted in cycle N -> ir_valid in N+2 (N+1 with FETCH_BYPASS_EN when the buffer is empty).
// Backpressure: a request issues only while in-flight + buffered < FIFO_DEPTH, so ir_ready low throttles fetch without overflow.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_8000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W  = CNT_W + 1;
    localparam int DROP_W = 8;

    localparam logic [31:0]      NOP      = 32'h0000_0013;
    localparam logic [OCC_W-1:0] DEPTH_O  = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_N  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Architectural fetch state.
    logic [31:0]       pc_q, pc_d;
    logic [CNT_W-1:0]  infl_q, infl_d;     // requests of the current stream awaiting data
    logic [DROP_W-1:0] drop_q, drop_d;     // stale responses still owed by memory

    // Tag queue: PC of each in-flight request of the current stream, oldest first.
    logic [31:0]       tag_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  tag_wr_q, tag_wr_d;
    logic [PTR_W-1:0]  tag_rd_q, tag_rd_d;

    // Instruction buffer: {pc, word} pairs waiting for decode.
    logic [31:0]       buf_ir_q [FIFO_DEPTH];
    logic [31:0]       buf_pc_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  buf_wr_q, buf_wr_d;
    logic [PTR_W-1:0]  buf_rd_q, buf_rd_d;
    logic [CNT_W-1:0]  buf_cnt_q, buf_cnt_d;

    // ir_pc holds its last presented value while ir_valid is low.
    logic [31:0]       last_pc_q;

    logic [OCC_W-1:0]  occ;
    logic              req_fire;
    logic              resp_drop;
    logic              resp_keep;
    logic              resp_live;
    logic [31:0]       resp_tag;
    logic              buf_empty;
    logic              byp_vld;
    logic              byp_take;
    logic              buf_push;
    logic              buf_pop;

    // Request issue and response classification.
    always_comb begin
        occ            = {1'b0, infl_q} + {1'b0, buf_cnt_q};
        imem_req_valid = rst_n && !redirect_valid && (occ < DEPTH_O);
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_drop      = imem_resp_valid && (drop_q != '0);
        resp_keep      = imem_resp_valid && (drop_q == '0) && (infl_q != '0);
        resp_live      = resp_drop || resp_keep;
        resp_tag       = tag_mem_q[tag_rd_q];
        buf_empty      = (buf_cnt_q == '0);
    end

    // Same-cycle bypass of a fresh response straight to decode when nothing is buffered.
    always_comb begin
        byp_vld = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp_vld = resp_keep && buf_empty && !redirect_valid;
`endif
        byp_take = byp_vld && ir_ready;
        buf_push = resp_keep && !redirect_valid && !byp_take;
        buf_pop  = !buf_empty && ir_ready && !redirect_valid;
    end

    // Decode-facing outputs: buffer head first, then bypass, otherwise NOP.
    always_comb begin
        ir_valid = 1'b0;
        ir       = NOP;
        ir_pc    = last_pc_q;
        if (!buf_empty) begin
            ir_valid = 1'b1;
            ir       = buf_ir_q[buf_rd_q];
            ir_pc    = buf_pc_q[buf_rd_q];
        end else if (byp_vld) begin
            ir_valid = 1'b1;
            ir       = imem_resp_data;
            ir_pc    = resp_tag;
        end
    end

    // Next-state: a redirect flushes everything and converts in-flight requests into drops.
    always_comb begin
        pc_d      = pc_q;
        infl_d    = infl_q;
        drop_d    = drop_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        buf_wr_d  = buf_wr_q;
        buf_rd_d  = buf_rd_q;
        buf_cnt_d = buf_cnt_q;
        if (redirect_valid) begin
            pc_d      = redirect_pc & 32'hFFFF_FFFC;
            infl_d    = '0;
            // Everything still owed by memory after this cycle's response is stale.
            drop_d    = drop_q + DROP_W'(infl_q) - DROP_W'(resp_live);
            tag_wr_d  = '0;
            tag_rd_d  = '0;
            buf_wr_d  = '0;
            buf_rd_d  = '0;
            buf_cnt_d = '0;
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + 32'd4;
                tag_wr_d = tag_wr_q + PTR_ONE;
            end
            if (resp_keep) begin
                tag_rd_d = tag_rd_q + PTR_ONE;
            end
            infl_d = infl_q + CNT_W'(req_fire) - CNT_W'(resp_keep);
            drop_d = drop_q - DROP_W'(resp_drop);
            if (buf_push) begin
                buf_wr_d = buf_wr_q + PTR_ONE;
            end
            if (buf_pop) begin
                buf_rd_d = buf_rd_q + PTR_ONE;
            end
            buf_cnt_d = buf_cnt_q + CNT_W'(buf_push) - CNT_W'(buf_pop);
        end
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            infl_q    <= '0;
            drop_q    <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            buf_wr_q  <= '0;
            buf_rd_q  <= '0;
            buf_cnt_q <= '0;
            last_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            drop_q    <= drop_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            buf_wr_q  <= buf_wr_d;
            buf_rd_q  <= buf_rd_d;
            buf_cnt_q <= buf_cnt_d;
            last_pc_q <= ir_pc;
        end
    end

    // Payload storage; contents are only meaningful behind the counters, so no reset.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem_q[tag_wr_q] <= pc_q;
        end
        if (buf_push) begin
            buf_ir_q[buf_wr_q] <= imem_resp_data;
            buf_pc_q[buf_wr_q] <= resp_tag;
        end
    end

    // A response with nothing outstanding is a memory protocol error; it is ignored above.
    a_resp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> ((infl_q != '0) || (drop_q != '0)));

    // Credit accounting must keep the buffer from overflowing.
    a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        buf_push |-> ((buf_cnt_q < DEPTH_N) || buf_pop));

    // A raised request holds its address until accepted unless a redirect withdraws it.
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (imem_req_valid && !imem_req_ready) |=>
            (redirect_valid || (imem_req_valid && $stable(imem_req_addr))));

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_8000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_LAT = 1;
    localparam int MIN_VLD30 = 30;
`else
    localparam int FIRST_LAT = 2;
    localparam int MIN_VLD30 = 20;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .ir_pc          (ir_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat_min = 1;
    int lat_max = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];   // requests accepted by the memory model, oldest first
    logic [31:0] exp_q[$];   // architectural PC stream decode is expected to see
    logic [31:0] exp_tail;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 64) begin
            exp_q.push_back(exp_tail);
            exp_tail = exp_tail + 32'd4;
        end
    endtask

    task automatic stream_restart(input logic [31:0] start);
        exp_q.delete();
        exp_tail = start;
        top_up();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        top_up();
    endtask

    // Memory: answers in order, one per cycle, each no earlier than its due cycle.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word_of(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
        end
    end

    // Memory: record accepted requests with a random latency.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{addr: imem_req_addr,
                              due: cyc + int'($urandom_range(lat_max, lat_min))});
        end
    end

    // Monitor: scoreboard on decode handshakes plus request-channel rules.
    int          live = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        logic        fire;
        logic        deliv;
        logic [31:0] e;
        if (!rst_n) begin
            live      = 0;
            prev_pend = 1'b0;
        end else begin
            fire  = imem_req_valid && imem_req_ready;
            deliv = ir_valid && ir_ready && !redirect_valid;
            if (prev_pend && !redirect_valid) begin
                check("req_hold_vld", {31'd0, imem_req_valid}, 32'd1);
                check("req_hold_addr", imem_req_addr, prev_addr);
            end
            if (imem_req_valid) begin
                check("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
            end
            if (deliv) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got pc %h with nothing expected", ir_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("ir_pc", ir_pc, e);
                    check("ir", ir, word_of(e));
                end
            end
            if (redirect_valid) live = 0;
            else live = live + int'(fire) - int'(deliv);
            check("outstanding_le_depth", {31'd0, (live <= DEPTH)}, 32'd1);
            prev_pend = imem_req_valid && !imem_req_ready;
            prev_addr = imem_req_addr;
        end
    end

    // Stimulus.
    initial begin
        int          n0;
        int          seen;
        int          nv;
        logic        found;
        logic [31:0] tgt;

        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ir_ready       = 1'b0;
        stream_restart(RESET_PC);
        repeat (3) step();

        @(negedge clk);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_ir", ir, NOP);
        check("rst_ir_pc", ir_pc, 32'd0);

        // Streaming from reset with single-cycle memory and an always-ready decoder.
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1;
        ir_ready       = 1'b1;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n0 = cyc;
        check("first_req_vld", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, RESET_PC);
        found = 1'b0;
        seen  = -1;
        for (int i = 0; i < 10 && !found; i++) begin
            if (ir_valid) begin
                found = 1'b1;
                seen  = cyc - n0;
            end else begin
                @(negedge clk);
            end
        end
        check("first_ir_latency", seen, FIRST_LAT);
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            if (ir_valid) nv++;
            @(negedge clk);
        end
        check("stream_valid_cycles", {31'd0, (nv >= MIN_VLD30)}, 32'd1);

        // Decoder stall for five cycles: fetch must throttle, nothing lost.
        step();
        ir_ready = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("stall_req_vld", {31'd0, imem_req_valid}, 32'd0);
        step();
        ir_ready = 1'b1;
        repeat (10) step();

        // Redirect to a misaligned target while two requests are in flight.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (mem_q.size() == 2) found = 1'b1;
        end
        check("two_in_flight", {31'd0, found}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_9002;
        stream_restart(32'h0000_9000);
        @(negedge clk);
        check("redir_req_vld", {31'd0, imem_req_valid}, 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("post_redir_req_vld", {31'd0, imem_req_valid}, 32'd1);
        check("post_redir_addr", imem_req_addr, 32'h0000_9000);
        repeat (20) step();

        // Redirect coinciding with a response and a decode pop.
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (imem_resp_valid && ir_valid) found = 1'b1;
        end
        check("resp_and_pop_seen", {31'd0, found}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_A000;
        stream_restart(32'h0000_A000);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("flush_ir_valid", {31'd0, ir_valid}, 32'd0);
        repeat (10) step();

        // Back-to-back redirects: the second one wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_B000;
        stream_restart(32'h0000_B000);
        step();
        redirect_pc    = 32'h0000_C004;
        stream_restart(32'h0000_C004);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("b2b_req_addr", imem_req_addr, 32'h0000_C004);
        repeat (10) step();

        // Random memory readiness, latency 1..3, decoder stalls and redirects.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            step();
            imem_req_ready = ($urandom_range(99, 0) < 60);
            ir_ready       = ($urandom_range(99, 0) < 75);
            if ($urandom_range(99, 0) < 3) begin
                if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
                else tgt = $urandom;
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                stream_restart(tgt & 32'hFFFF_FFFC);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        step();
        redirect_valid = 1'b0;
        ir_ready       = 1'b1;
        imem_req_ready = 1'b1;
        repeat (20) step();

        // Asynchronous reset in the middle of a stream.
        rst_n = 1'b0;
        #1;
        check("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("arst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("arst_ir", ir, NOP);
        check("arst_ir_pc", ir_pc, 32'd0);
        stream_restart(RESET_PC);
        lat_min = 1; lat_max = 1;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_req_vld", {31'd0, imem_req_valid}, 32'd1);
        check("restart_req_addr", imem_req_addr, RESET_PC);
        repeat (30) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: run still active at %0t, limit 400000", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
